// File: rtl/spi_frame_pkg.sv
// Shared types and defaults for the SPI frame sequencer.
package spi_frame_pkg;

    localparam int          DEFAULT_ADDR_WIDTH = 11;
    localparam logic [31:0] DEFAULT_BUSY_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_REPLY_CNT,
        ST_REPLY_DATA
    } state_t;

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Word, RAM and core signals of the frame sequencer.
// The master side is the controller; the slave side is its environment.
interface spi_frame_ctrl_if #(
    parameter int ADDR_WIDTH = 11
);
    // SPI slave word interface
    logic                  rx_valid;
    logic [31:0]           rx_data;
    logic [31:0]           tx_data;
    // Shared RAM port
    logic                  mem_own;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    // Subdivision core handshake
    logic                  core_start;
    logic                  core_done;
    logic [31:0]           core_words;
    // Status
    logic                  busy;
    logic                  ovf;

    modport master (
        input  rx_valid, rx_data, mem_rdata, core_done, core_words,
        output tx_data, mem_own, mem_addr, mem_we, mem_wdata,
               core_start, busy, ovf
    );

    modport slave (
        output rx_valid, rx_data, mem_rdata, core_done, core_words,
        input  tx_data, mem_own, mem_addr, mem_we, mem_wdata,
               core_start, busy, ovf
    );

endinterface

// File: rtl/spi_frame_ctrl.sv
// Word-level sequencer: loads an inbound frame into RAM, starts the core,
// answers polls with a busy word, then streams the result back out.
module spi_frame_ctrl
    import spi_frame_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [31:0] BUSY_WORD  = DEFAULT_BUSY_WORD
) (
    input logic             clk,
    input logic             rstb,
    spi_frame_ctrl_if.master bus
);

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    state_t      state;
    logic [31:0] n_words;    // inbound payload length N
    logic [31:0] m_words;    // result length M, clamped to RAM capacity
    logic [31:0] index;      // payload / result word index
    logic        rd_pend;    // RAM read issued last cycle, data arrives now
    logic [31:0] tx_data;
    logic        core_start;
    logic        busy;
    logic        ovf;

    logic        in_range;
    logic        last_load;
    logic        last_reply;
    logic [31:0] addr_idx;

    assign in_range   = index < CAPACITY;
    assign last_load  = index == n_words - 32'd1;
    assign last_reply = index == m_words - 32'd1;

    // Read address runs one word ahead on a streaming exchange so the next
    // result word is fetched in the rx_valid cycle itself.
    always_comb begin
        addr_idx = index;
        if (state == ST_REPLY_DATA && bus.rx_valid && !last_reply) begin
            addr_idx = index + 32'd1;
        end
    end

    // RAM write is combinational from the registered index and the live word.
    assign bus.mem_own   = state != ST_RUN;
    assign bus.mem_we    = state == ST_LOAD && bus.rx_valid && in_range;
    assign bus.mem_addr  = addr_idx[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = bus.mem_we ? bus.rx_data : 32'd0;

    assign bus.tx_data    = tx_data;
    assign bus.core_start = core_start;
    assign bus.busy       = busy;
    assign bus.ovf        = ovf;

    // Frame sequencing FSM with registered outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_IDLE;
            n_words    <= '0;
            m_words    <= '0;
            index      <= '0;
            rd_pend    <= 1'b0;
            tx_data    <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            core_start <= 1'b0;
            rd_pend    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_data <= '0;
                    if (bus.rx_valid) begin
                        n_words <= bus.rx_data;
                        index   <= '0;
                        ovf     <= 1'b0;
                        if (bus.rx_data == 32'd0) begin
                            state      <= ST_RUN;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            tx_data    <= BUSY_WORD;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.rx_valid) begin
                        if (!in_range) begin
                            ovf <= 1'b1;
                        end
                        if (last_load) begin
                            state      <= ST_RUN;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            tx_data    <= BUSY_WORD;
                            index      <= '0;
                        end else begin
                            index <= index + 32'd1;
                        end
                    end
                end
                ST_RUN: begin
                    // Polls are ignored here; a coincident poll keeps BUSY_WORD.
                    if (bus.core_done) begin
                        m_words <= (bus.core_words > CAPACITY) ? CAPACITY : bus.core_words;
                        tx_data <= bus.core_words;
                        busy    <= 1'b0;
                        index   <= '0;
                        state   <= ST_REPLY_CNT;
                    end
                end
                ST_REPLY_CNT: begin
                    if (bus.rx_valid) begin
                        if (m_words == 32'd0) begin
                            tx_data <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            rd_pend <= 1'b1;
                            state   <= ST_REPLY_DATA;
                        end
                    end
                end
                ST_REPLY_DATA: begin
                    if (rd_pend) begin
                        tx_data <= bus.mem_rdata;
                    end
                    if (bus.rx_valid) begin
                        if (last_reply) begin
                            tx_data <= '0;
                            index   <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            index   <= index + 32'd1;
                            rd_pend <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: scoreboard queues of expected tx words
// and RAM writes, filled as each exchange is driven and drained as it completes.
module tb_spi_frame_ctrl;
    import spi_frame_pkg::*;

    localparam int          AW    = 11;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BUSY  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    spi_frame_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    spi_frame_ctrl #(.ADDR_WIDTH(AW), .BUSY_WORD(BUSY)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    // Shared RAM with a core-side port selected by mem_own
    logic [31:0]   ram [DEPTH];
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;

    assign ram_we    = bus.mem_own ? bus.mem_we    : core_we;
    assign ram_addr  = bus.mem_own ? bus.mem_addr  : core_addr;
    assign ram_wdata = bus.mem_own ? bus.mem_wdata : core_wdata;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        bus.mem_rdata <= ram[ram_addr];
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic [31:0] tx_q [$];
    wr_t         wr_q [$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_xfer(input logic [31:0] tx, input logic we = 1'b0,
                               input logic [AW-1:0] addr = '0, input logic [31:0] data = '0);
        wr_t w;
        w.we = we; w.addr = addr; w.data = data;
        tx_q.push_back(tx);
        wr_q.push_back(w);
    endtask

    // One word exchange, started on a falling edge; returns on the next one.
    task automatic xfer(input logic [31:0] word, input logic done = 1'b0,
                        input logic [31:0] m = '0);
        wr_t         w;
        logic [31:0] t;
        bus.rx_valid   = 1'b1;
        bus.rx_data    = word;
        bus.core_done  = done;
        bus.core_words = m;
        #1;
        if (tx_q.size() == 0 || wr_q.size() == 0) begin
            check("scoreboard_empty", 32'(tx_q.size()), 32'd1);
        end else begin
            t = tx_q.pop_front();
            w = wr_q.pop_front();
            check("tx_data", bus.tx_data, t);
            check("mem_we", 32'(bus.mem_we), 32'(w.we));
            if (w.we) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
                check("mem_wdata", bus.mem_wdata, w.data);
            end
        end
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        bus.core_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [31:0] d);
        core_we = 1'b1; core_addr = a; core_wdata = d;
        @(negedge clk);
        core_we = 1'b0;
    endtask

    task automatic core_pulse(input logic [31:0] m);
        bus.core_done  = 1'b1;
        bus.core_words = m;
        @(negedge clk);
        bus.core_done = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_tx_data"},    bus.tx_data, 32'd0);
        check({pfx, "_mem_own"},    32'(bus.mem_own), 32'd1);
        check({pfx, "_mem_we"},     32'(bus.mem_we), 32'd0);
        check({pfx, "_mem_addr"},   32'(bus.mem_addr), 32'd0);
        check({pfx, "_mem_wdata"},  bus.mem_wdata, 32'd0);
        check({pfx, "_core_start"}, 32'(bus.core_start), 32'd0);
        check({pfx, "_busy"},       32'(bus.busy), 32'd0);
        check({pfx, "_ovf"},        32'(bus.ovf), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = '0;
        bus.core_done = 1'b0; bus.core_words = '0;
        core_we = 1'b0; core_addr = '0; core_wdata = '0;
        idle(2);
        check_reset("reset");
        rstb = 1'b1;
        idle(2);

        // Frame N=3 {5,6,7}
        expect_xfer(32'd0);              xfer(32'd3); idle(3);
        expect_xfer(32'd0, 1'b1, 0, 5);  xfer(32'd5); idle(3);
        expect_xfer(32'd0, 1'b1, 1, 6);  xfer(32'd6); idle(3);
        expect_xfer(32'd0, 1'b1, 2, 7);  xfer(32'd7);
        check("start_pulse", 32'(bus.core_start), 32'd1);
        check("run_mem_own", 32'(bus.mem_own), 32'd0);
        check("run_busy", 32'(bus.busy), 32'd1);
        idle(1);
        check("start_single", 32'(bus.core_start), 32'd0);
        check("busy_held", 32'(bus.busy), 32'd1);
        idle(2);

        // Polls while the core runs, then the result M=2 {A,B}
        expect_xfer(BUSY); xfer(32'h0); idle(3);
        expect_xfer(BUSY); xfer(32'h0); idle(1);
        core_write(0, 32'hA);
        core_write(1, 32'hB);
        core_pulse(32'd2);
        check("done_busy_low", 32'(bus.busy), 32'd0);
        check("done_tx_m", bus.tx_data, 32'd2);
        check("done_mem_own", 32'(bus.mem_own), 32'd1);
        expect_xfer(32'd2);  xfer(32'h0); idle(3);
        expect_xfer(32'hA);  xfer(32'h0); idle(3);
        expect_xfer(32'hB);  xfer(32'h0);
        check("reply_idle_tx", bus.tx_data, 32'd0);
        idle(3);

        // N=0: start straight after the header; M=0 reply
        expect_xfer(32'd0); xfer(32'd0);
        check("n0_start", 32'(bus.core_start), 32'd1);
        check("n0_busy", 32'(bus.busy), 32'd1);
        check("n0_tx_busy", bus.tx_data, BUSY);
        idle(2);
        core_pulse(32'd0);
        check("m0_tx", bus.tx_data, 32'd0);
        expect_xfer(32'd0); xfer(32'h0);
        check("m0_addr", 32'(bus.mem_addr), 32'd0);
        idle(3);

        // Overflowing frame N = capacity + 2
        expect_xfer(32'd0); xfer(32'(DEPTH + 2)); idle(1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            expect_xfer(32'd0, i < DEPTH, AW'(i), 32'h100 + 32'(i));
            xfer(32'h100 + 32'(i));
            if (i == DEPTH - 1) check("ovf_not_yet", 32'(bus.ovf), 32'd0);
            if (i < DEPTH + 1) idle(1);
        end
        check("ovf_start", 32'(bus.core_start), 32'd1);
        check("ovf_set", 32'(bus.ovf), 32'd1);
        idle(2);
        core_pulse(32'd0);
        expect_xfer(32'd0); xfer(32'h0); idle(3);

        // Next header clears ovf; reset after the first of four words
        expect_xfer(32'd0); xfer(32'd4);
        check("ovf_cleared", 32'(bus.ovf), 32'd0);
        idle(2);
        expect_xfer(32'd0, 1'b1, 0, 32'h11); xfer(32'h11); idle(2);
        bus.rx_valid = 1'b1; bus.rx_data = 32'h22;
        rstb = 1'b0;
        #1;
        check_reset("midload");
        @(negedge clk);
        bus.rx_valid = 1'b0;
        idle(1);
        rstb = 1'b1;
        idle(2);

        // Fresh frame N=1 {9}
        expect_xfer(32'd0);             xfer(32'd1); idle(3);
        expect_xfer(32'd0, 1'b1, 0, 9); xfer(32'd9);
        check("n1_start", 32'(bus.core_start), 32'd1);
        idle(3);

        // core_done coincident with a poll: poll sees BUSY, next sees M
        expect_xfer(BUSY); xfer(32'h33, 1'b1, 32'd1);
        check("coinc_busy_low", 32'(bus.busy), 32'd0);
        check("coinc_tx_m", bus.tx_data, 32'd1);
        idle(3);
        expect_xfer(32'd1); xfer(32'h0); idle(3);
        expect_xfer(32'd9); xfer(32'h0);
        check("coinc_idle_tx", bus.tx_data, 32'd0);
        idle(2);

        check("scoreboard_drained", 32'(tx_q.size() + wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
